// File: rtl/node_collision_scheduler_if.sv
// rtl/node_collision_scheduler_if.sv - frame control, node RAM and collisions engine signal bundle
interface node_collision_scheduler_if #(
  parameter int NUM_NODES     = 8,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 7,
  parameter int FORCE_SIZE    = 8
);
  localparam int IDXW = $clog2(NUM_NODES);
  localparam int ACCW = FORCE_SIZE + IDXW;

  // frame control
  logic                            begin_in;
  logic [NUM_NODES-1:0]            active_mask_in;
  logic                            busy_out;
  logic                            done_out;
  logic                            error_out;
  logic signed [ACCW-1:0]          force_x_out;
  logic signed [ACCW-1:0]          force_y_out;

  // node RAM read port
  logic [IDXW-1:0]                 node_rd_idx_out;
  logic signed [POSITION_SIZE-1:0] node_pos_x_in;
  logic signed [POSITION_SIZE-1:0] node_pos_y_in;
  logic signed [VELOCITY_SIZE-1:0] node_vel_x_in;
  logic signed [VELOCITY_SIZE-1:0] node_vel_y_in;

  // collisions engine
  logic                            eng_begin_out;
  logic signed [POSITION_SIZE-1:0] eng_pos_x_out;
  logic signed [POSITION_SIZE-1:0] eng_pos_y_out;
  logic signed [VELOCITY_SIZE-1:0] eng_vel_x_out;
  logic signed [VELOCITY_SIZE-1:0] eng_vel_y_out;
  logic                            eng_result_in;
  logic signed [POSITION_SIZE-1:0] eng_new_pos_x_in;
  logic signed [POSITION_SIZE-1:0] eng_new_pos_y_in;
  logic signed [VELOCITY_SIZE-1:0] eng_new_vel_x_in;
  logic signed [VELOCITY_SIZE-1:0] eng_new_vel_y_in;
  logic signed [FORCE_SIZE-1:0]    eng_force_x_in;
  logic signed [FORCE_SIZE-1:0]    eng_force_y_in;

  // node RAM write-back port
  logic                            wr_en_out;
  logic [IDXW-1:0]                 wr_idx_out;
  logic signed [POSITION_SIZE-1:0] wr_pos_x_out;
  logic signed [POSITION_SIZE-1:0] wr_pos_y_out;
  logic signed [VELOCITY_SIZE-1:0] wr_vel_x_out;
  logic signed [VELOCITY_SIZE-1:0] wr_vel_y_out;

  // scheduler side
  modport slave (
    input  begin_in, active_mask_in,
    input  node_pos_x_in, node_pos_y_in, node_vel_x_in, node_vel_y_in,
    input  eng_result_in, eng_new_pos_x_in, eng_new_pos_y_in,
    input  eng_new_vel_x_in, eng_new_vel_y_in, eng_force_x_in, eng_force_y_in,
    output busy_out, done_out, error_out, force_x_out, force_y_out,
    output node_rd_idx_out,
    output eng_begin_out, eng_pos_x_out, eng_pos_y_out, eng_vel_x_out, eng_vel_y_out,
    output wr_en_out, wr_idx_out, wr_pos_x_out, wr_pos_y_out, wr_vel_x_out, wr_vel_y_out
  );

  // frame controller / RAM / engine side
  modport master (
    output begin_in, active_mask_in,
    output node_pos_x_in, node_pos_y_in, node_vel_x_in, node_vel_y_in,
    output eng_result_in, eng_new_pos_x_in, eng_new_pos_y_in,
    output eng_new_vel_x_in, eng_new_vel_y_in, eng_force_x_in, eng_force_y_in,
    input  busy_out, done_out, error_out, force_x_out, force_y_out,
    input  node_rd_idx_out,
    input  eng_begin_out, eng_pos_x_out, eng_pos_y_out, eng_vel_x_out, eng_vel_y_out,
    input  wr_en_out, wr_idx_out, wr_pos_x_out, wr_pos_y_out, wr_vel_x_out, wr_vel_y_out
  );
endinterface

// File: rtl/node_collision_scheduler.sv
// rtl/node_collision_scheduler.sv - time-shares one collisions engine across all soft-body nodes of a frame
module node_collision_scheduler #(
  parameter int NUM_NODES     = 8,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 7,
  parameter int FORCE_SIZE    = 8,
  parameter int TIMEOUT       = 255
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  node_collision_scheduler_if.slave bus
);
  localparam int IDXW = $clog2(NUM_NODES);
  localparam int ACCW = FORCE_SIZE + IDXW;
  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_NODES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t                          state_q, state_d, adv_state;
  logic [IDXW-1:0]                 idx_q, idx_d, adv_idx;
  logic [NUM_NODES-1:0]            mask_q;
  logic [CNTW-1:0]                 cnt_q;
  logic                            is_last;
  logic                            timeout_hit;

  logic [IDXW-1:0]                 rd_idx_q;
  logic                            eng_begin_q;
  logic signed [POSITION_SIZE-1:0] eng_pos_x_q, eng_pos_y_q;
  logic signed [VELOCITY_SIZE-1:0] eng_vel_x_q, eng_vel_y_q;
  logic                            wr_en_q;
  logic [IDXW-1:0]                 wr_idx_q;
  logic signed [POSITION_SIZE-1:0] wr_pos_x_q, wr_pos_y_q;
  logic signed [VELOCITY_SIZE-1:0] wr_vel_x_q, wr_vel_y_q;
  logic signed [FORCE_SIZE-1:0]    frc_x_q, frc_y_q;
  logic signed [ACCW-1:0]          acc_x_q, acc_y_q;
  logic signed [ACCW-1:0]          force_x_q, force_y_q;
  logic                            busy_q, done_q, error_q;

  // After a node is finished (skipped, written or abandoned) move to the next index or finish the frame
  assign is_last     = (idx_q == IDX_LAST);
  assign adv_state   = is_last ? S_DONE : S_FETCH;
  assign adv_idx     = is_last ? idx_q : idx_q + IDXW'(1);
  // A result arriving on the expiry cycle takes priority, so expiry requires the result to be absent
  assign timeout_hit = (state_q == S_WAIT) && !bus.eng_result_in && (cnt_q == CNT_LAST);

  // Next-state and node index selection
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.begin_in) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end
      S_FETCH: begin
        if (mask_q[idx_q]) begin
          state_d = S_LAUNCH;
        end else begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.eng_result_in) begin
          state_d = S_WRITE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end
      end
      S_WRITE: begin
        state_d = adv_state;
        idx_d   = adv_idx;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and node index registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Registered outputs, engine operand/result capture and frame force accumulation
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mask_q      <= '0;
      cnt_q       <= '0;
      rd_idx_q    <= '0;
      eng_begin_q <= 1'b0;
      eng_pos_x_q <= '0;
      eng_pos_y_q <= '0;
      eng_vel_x_q <= '0;
      eng_vel_y_q <= '0;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      wr_pos_x_q  <= '0;
      wr_pos_y_q  <= '0;
      wr_vel_x_q  <= '0;
      wr_vel_y_q  <= '0;
      frc_x_q     <= '0;
      frc_y_q     <= '0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      force_x_q   <= '0;
      force_y_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      eng_begin_q <= (state_q == S_LAUNCH);
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      // The RAM address follows the node about to be fetched; it is held while that node is in flight
      if (state_d == S_FETCH) begin
        rd_idx_q <= idx_d;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.begin_in) begin
            mask_q  <= bus.active_mask_in;
            acc_x_q <= '0;
            acc_y_q <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_LAUNCH: begin
          eng_pos_x_q <= bus.node_pos_x_in;
          eng_pos_y_q <= bus.node_pos_y_in;
          eng_vel_x_q <= bus.node_vel_x_in;
          eng_vel_y_q <= bus.node_vel_y_in;
          cnt_q       <= '0;
        end
        S_WAIT: begin
          if (bus.eng_result_in) begin
            wr_en_q    <= 1'b1;
            wr_idx_q   <= idx_q;
            wr_pos_x_q <= bus.eng_new_pos_x_in;
            wr_pos_y_q <= bus.eng_new_pos_y_in;
            wr_vel_x_q <= bus.eng_new_vel_x_in;
            wr_vel_y_q <= bus.eng_new_vel_y_in;
            frc_x_q    <= bus.eng_force_x_in;
            frc_y_q    <= bus.eng_force_y_in;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
            if (timeout_hit) begin
              error_q <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          // Accumulator is wide enough for NUM_NODES worst-case forces, so no saturation is needed
          acc_x_q <= acc_x_q + {{IDXW{frc_x_q[FORCE_SIZE-1]}}, frc_x_q};
          acc_y_q <= acc_y_q + {{IDXW{frc_y_q[FORCE_SIZE-1]}}, frc_y_q};
        end
        S_DONE: begin
          force_x_q <= acc_x_q;
          force_y_q <= acc_y_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.node_rd_idx_out = rd_idx_q;
  assign bus.eng_begin_out   = eng_begin_q;
  assign bus.eng_pos_x_out   = eng_pos_x_q;
  assign bus.eng_pos_y_out   = eng_pos_y_q;
  assign bus.eng_vel_x_out   = eng_vel_x_q;
  assign bus.eng_vel_y_out   = eng_vel_y_q;
  assign bus.wr_en_out       = wr_en_q;
  assign bus.wr_idx_out      = wr_idx_q;
  assign bus.wr_pos_x_out    = wr_pos_x_q;
  assign bus.wr_pos_y_out    = wr_pos_y_q;
  assign bus.wr_vel_x_out    = wr_vel_x_q;
  assign bus.wr_vel_y_out    = wr_vel_y_q;
  assign bus.force_x_out     = force_x_q;
  assign bus.force_y_out     = force_y_q;
  assign bus.busy_out        = busy_q;
  assign bus.done_out        = done_q;
  assign bus.error_out       = error_q;
endmodule

// File: tb/tb_node_collision_scheduler.sv
// tb/tb_node_collision_scheduler.sv - randomized frames checked against a frame timeline model
module tb_node_collision_scheduler;
  localparam int N    = 8;
  localparam int PS   = 8;
  localparam int VS   = 7;
  localparam int FS   = 8;
  localparam int TO   = 255;
  localparam int MAXT = 4200;
  localparam int NEVER = 1000000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  node_collision_scheduler_if #(.NUM_NODES(N), .POSITION_SIZE(PS), .VELOCITY_SIZE(VS), .FORCE_SIZE(FS)) bus ();

  node_collision_scheduler #(
    .NUM_NODES(N), .POSITION_SIZE(PS), .VELOCITY_SIZE(VS), .FORCE_SIZE(FS), .TIMEOUT(TO)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int cur_t  = -1;

  // stimulus tables: node RAM contents and engine behaviour per node (lat 0 = engine never answers)
  int ram_px[N], ram_py[N], ram_vx[N], ram_vy[N];
  int res_px[N], res_py[N], res_vx[N], res_vy[N], res_fx[N], res_fy[N];
  int lat[N];
  logic [N-1:0] mask;

  // expected frame timeline, indexed by cycles after the edge that accepts begin_in
  bit e_beg[MAXT];
  int e_beg_idx[MAXT];
  bit e_wr[MAXT];
  int e_wr_idx[MAXT];
  int e_rd[MAXT];
  int beg_t[N];
  int t_end, t_err, e_fx, e_fy;
  int t0 = 0;
  bit frame_active = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0d required=%0d", name, cur_t, act, exp);
    end
  endtask

  // Walk the nodes: skipped node = 1 cycle; active node = fetch, launch, wait (L+1 cycles, result
  // L cycles after the launch pulse, capped at TO), then a write cycle unless the wait expired.
  task automatic build_model();
    int t, w;
    bit ok;
    for (int k = 0; k < MAXT; k++) begin
      e_beg[k] = 0; e_wr[k] = 0; e_rd[k] = -1; e_beg_idx[k] = 0; e_wr_idx[k] = 0;
    end
    t = 0; t_err = NEVER; e_fx = 0; e_fy = 0;
    for (int i = 0; i < N; i++) begin
      e_rd[t] = i;
      beg_t[i] = -1;
      if (!mask[i]) begin
        t += 1;
      end else begin
        ok = (lat[i] != 0) && (lat[i] + 1 <= TO);
        w  = ok ? lat[i] + 1 : TO;
        beg_t[i] = t + 2;
        e_beg[t + 2] = 1; e_beg_idx[t + 2] = i;
        if (ok) begin
          e_wr[t + 2 + w] = 1; e_wr_idx[t + 2 + w] = i;
          e_fx += res_fx[i]; e_fy += res_fy[i];
          t += w + 3;
        end else begin
          if (t_err == NEVER) t_err = t + 2 + w;
          t += w + 2;
        end
      end
    end
    t_end = t;
  endtask

  task automatic randomize_tables();
    for (int i = 0; i < N; i++) begin
      ram_px[i] = int'($urandom_range(0, 255)) - 128; ram_py[i] = int'($urandom_range(0, 255)) - 128;
      ram_vx[i] = int'($urandom_range(0, 127)) - 64;  ram_vy[i] = int'($urandom_range(0, 127)) - 64;
      res_px[i] = int'($urandom_range(0, 255)) - 128; res_py[i] = int'($urandom_range(0, 255)) - 128;
      res_vx[i] = int'($urandom_range(0, 127)) - 64;  res_vy[i] = int'($urandom_range(0, 127)) - 64;
      res_fx[i] = int'($urandom_range(0, 255)) - 128; res_fy[i] = int'($urandom_range(0, 255)) - 128;
      lat[i]    = int'($urandom_range(1, 6));
    end
  endtask

  // node RAM (one-cycle read latency) and collisions engine models
  int prev_addr = 0;
  int rem = -1;
  int enode = 0;
  bit spur = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      bus.node_pos_x_in = PS'(ram_px[prev_addr]);
      bus.node_pos_y_in = PS'(ram_py[prev_addr]);
      bus.node_vel_x_in = VS'(ram_vx[prev_addr]);
      bus.node_vel_y_in = VS'(ram_vy[prev_addr]);
      prev_addr = int'(bus.node_rd_idx_out);
      bus.eng_result_in    = 1'b0;
      bus.eng_new_pos_x_in = PS'($urandom); bus.eng_new_pos_y_in = PS'($urandom);
      bus.eng_new_vel_x_in = VS'($urandom); bus.eng_new_vel_y_in = VS'($urandom);
      bus.eng_force_x_in   = FS'($urandom); bus.eng_force_y_in   = FS'($urandom);
      if (!rst_n) begin
        rem = -1; spur = 1'b0;
      end
      if (spur) begin
        bus.eng_result_in = 1'b1;
        spur = 1'b0;
      end
      if (bus.eng_begin_out) begin
        enode = int'(bus.node_rd_idx_out);
        rem = (lat[enode] == 0) ? -1 : lat[enode];
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          bus.eng_result_in    = 1'b1;
          bus.eng_new_pos_x_in = PS'(res_px[enode]); bus.eng_new_pos_y_in = PS'(res_py[enode]);
          bus.eng_new_vel_x_in = VS'(res_vx[enode]); bus.eng_new_vel_y_in = VS'(res_vy[enode]);
          bus.eng_force_x_in   = FS'(res_fx[enode]); bus.eng_force_y_in   = FS'(res_fy[enode]);
          rem  = -1;
          spur = bit'($urandom_range(0, 1));
        end
      end
    end
  end

  // per-cycle comparison of every DUT output against the timeline model
  initial begin
    int t, i;
    forever begin
      @(posedge clk); #1;
      if (frame_active && rst_n) begin
        t = cyc - t0;
        cur_t = t;
        if (t >= 0 && t < MAXT) begin
          chk("busy", bus.busy_out, longint'(t <= t_end));
          chk("done", bus.done_out, longint'(t == t_end + 1));
          chk("error", bus.error_out, longint'(t >= t_err));
          chk("eng_begin", bus.eng_begin_out, e_beg[t]);
          if (e_beg[t]) begin
            i = e_beg_idx[t];
            chk("eng_pos_x", bus.eng_pos_x_out, ram_px[i]);
            chk("eng_pos_y", bus.eng_pos_y_out, ram_py[i]);
            chk("eng_vel_x", bus.eng_vel_x_out, ram_vx[i]);
            chk("eng_vel_y", bus.eng_vel_y_out, ram_vy[i]);
          end
          chk("wr_en", bus.wr_en_out, e_wr[t]);
          if (e_wr[t]) begin
            i = e_wr_idx[t];
            chk("wr_idx", bus.wr_idx_out, i);
            chk("wr_pos_x", bus.wr_pos_x_out, res_px[i]);
            chk("wr_pos_y", bus.wr_pos_y_out, res_py[i]);
            chk("wr_vel_x", bus.wr_vel_x_out, res_vx[i]);
            chk("wr_vel_y", bus.wr_vel_y_out, res_vy[i]);
          end
          if (e_rd[t] >= 0) chk("rd_idx", bus.node_rd_idx_out, e_rd[t]);
          if (t == t_end + 1) begin
            chk("force_x", bus.force_x_out, e_fx);
            chk("force_y", bus.force_y_out, e_fy);
          end
        end
      end
    end
  end

  // Accept a frame and let it run to completion; optionally pulse begin_in mid-frame and in DONE
  task automatic run_frame(input bit mid);
    int tt;
    frame_active = 1'b0;
    build_model();
    @(posedge clk); #1;
    bus.active_mask_in = mask;
    bus.begin_in = 1'b1;
    t0 = cyc + 1;
    frame_active = 1'b1;
    for (int k = 0; k < MAXT; k++) begin
      @(posedge clk); #1;
      tt = cyc - t0;
      bus.begin_in = mid && (tt == 5 || tt == t_end);
      bus.active_mask_in = N'($urandom);
      if (tt > t_end + 3) break;
    end
    bus.begin_in = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy_out, 0);
    chk({tag, "_done"}, bus.done_out, 0);
    chk({tag, "_error"}, bus.error_out, 0);
    chk({tag, "_eng_begin"}, bus.eng_begin_out, 0);
    chk({tag, "_eng_pos_x"}, bus.eng_pos_x_out, 0);
    chk({tag, "_rd_idx"}, bus.node_rd_idx_out, 0);
    chk({tag, "_wr_en"}, bus.wr_en_out, 0);
    chk({tag, "_force_x"}, bus.force_x_out, 0);
    chk({tag, "_force_y"}, bus.force_y_out, 0);
  endtask

  initial begin
    int tt;
    bus.begin_in = 1'b0; bus.active_mask_in = '0; bus.eng_result_in = 1'b0;
    mask = '0;
    randomize_tables();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // all nodes, L=4, force_x=+3 each
    randomize_tables();
    mask = 8'hFF;
    for (int i = 0; i < N; i++) begin lat[i] = 4; res_fx[i] = 3; end
    build_model();
    chk("model_done_latency", t_end + 1, 65);
    chk("model_force_x_ff", e_fx, 24);
    run_frame(1'b0);
    chk("force_x_ff", bus.force_x_out, 24);
    chk("error_ff", bus.error_out, 0);

    // empty mask: only fetch cycles, no launches or writes
    randomize_tables();
    mask = 8'h00;
    build_model();
    chk("model_done_latency_empty", t_end + 1, 9);
    run_frame(1'b0);
    chk("force_x_empty", bus.force_x_out, 0);
    chk("force_y_empty", bus.force_y_out, 0);

    // most negative force on every node
    randomize_tables();
    mask = 8'hFF;
    for (int i = 0; i < N; i++) res_fx[i] = -128;
    run_frame(1'b0);
    chk("force_x_min", bus.force_x_out, -1024);

    // node 3 engine silent
    randomize_tables();
    mask = 8'hFF;
    lat[3] = 0;
    run_frame(1'b0);
    chk("error_node3", bus.error_out, 1);

    // begin_in pulsed mid-frame and during DONE
    randomize_tables();
    mask = 8'b1011_0110;
    run_frame(1'b1);

    // result on the expiry cycle wins; one cycle later is a timeout
    randomize_tables();
    mask = 8'h01;
    lat[0] = TO - 1;
    run_frame(1'b0);
    chk("error_same_cycle", bus.error_out, 0);
    chk("force_x_same_cycle", bus.force_x_out, res_fx[0]);
    lat[0] = TO;
    run_frame(1'b0);
    chk("error_late", bus.error_out, 1);
    chk("force_x_late", bus.force_x_out, 0);

    // reset during the wait of node 2, then a clean frame
    randomize_tables();
    mask = 8'hFF;
    for (int i = 0; i < N; i++) lat[i] = 3;
    frame_active = 1'b0;
    build_model();
    @(posedge clk); #1;
    bus.active_mask_in = mask;
    bus.begin_in = 1'b1;
    t0 = cyc + 1;
    @(posedge clk); #1;
    bus.begin_in = 1'b0;
    for (int k = 0; k < MAXT; k++) begin
      tt = cyc - t0;
      if (tt >= beg_t[2] + 1) break;
      @(posedge clk); #1;
    end
    cur_t = tt;
    chk("busy_before_reset", bus.busy_out, 1);
    chk("rd_idx_before_reset", bus.node_rd_idx_out, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("held_reset");
    rst_n = 1'b1;
    randomize_tables();
    mask = 8'hFF;
    run_frame(1'b0);
    chk("error_after_reset", bus.error_out, 0);

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      randomize_tables();
      mask = N'($urandom);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 15) == 0) lat[i] = 0;
      run_frame(bit'($urandom_range(0, 1)));
    end

    frame_active = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
